// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC port ids, flit type encoding, FSM states and field positions
package noc_pkg;
    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_WEST  = 3'd1;
    localparam logic [2:0] PORT_NORTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_SOUTH = 3'd4;
    localparam int TYPE_W = 2;
    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ipb_state_t;
    function automatic logic opens_packet(input flit_type_t t);
        return t == HEAD || t == SINGLE;
    endfunction
    function automatic logic closes_packet(input flit_type_t t);
        return t == TAIL || t == SINGLE;
    endfunction
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: power-of-two flit FIFO with free-running wrap pointers and occupancy count
module noc_flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    assign rdata = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/input_port_buffer.sv
// input_port_buffer: per-input flit FIFO with XY routing and head-to-tail route hold.
// Define INPUT_BUFFER_CREDIT_EN to add a credit_out pulse on every FIFO pop.
module input_port_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_W  = 32,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    parameter int X_ADDR  = 0,
    parameter int Y_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              buffer_req,
    output logic [2:0]        buffer_dport,
    input  logic              buffer_grant,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic              drop_pulse
`ifdef INPUT_BUFFER_CREDIT_EN
    ,
    output logic              credit_out
`endif
);
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ADDR);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ADDR);
    ipb_state_t state;
    logic full;
    logic empty;
    logic [$clog2(DEPTH):0] count;
    logic push;
    logic pop;
    logic drop;
    logic start;
    flit_type_t head_type;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [2:0] route;
    noc_flit_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_flit),
        .pop   (pop),
        .rdata (out_flit),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head_type  = flit_type_t'(out_flit[FLIT_W-1 -: TYPE_W]);
    assign dest_x     = out_flit[2*COORD_W-1:COORD_W];
    assign dest_y     = out_flit[COORD_W-1:0];
    assign start      = state == IDLE && !empty && opens_packet(head_type);
    // A BODY/TAIL at the head while idle has no route; discard it so the queue cannot wedge.
    assign drop       = state == IDLE && !empty && !opens_packet(head_type);
    assign buffer_req = state == ACTIVE && count != '0;
    assign out_valid  = buffer_req && buffer_grant;
    assign pop        = out_valid || drop;
    assign route      = dest_x > MY_X ? PORT_EAST  :
                        dest_x < MY_X ? PORT_WEST  :
                        dest_y > MY_Y ? PORT_SOUTH :
                        dest_y < MY_Y ? PORT_NORTH : PORT_LOCAL;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            buffer_dport <= PORT_LOCAL;
            drop_pulse   <= 1'b0;
        end else begin
            state        <= start ? ACTIVE :
                            (out_valid && closes_packet(head_type)) ? IDLE : state;
            buffer_dport <= start ? route : buffer_dport;
            drop_pulse   <= drop;
        end
    end
`ifdef INPUT_BUFFER_CREDIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit_out <= 1'b0;
        else        credit_out <= pop;
    end
`endif
endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed and random stimulus against a queue-based packet model.
module tb_input_port_buffer;
    localparam int FW = 32;
    localparam int D  = 4;
    localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;
    typedef struct {
        bit v;
        logic [FW-1:0] f;
        bit g;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic buffer_grant = 1'b0;
    logic in_ready, buffer_req, out_valid, drop_pulse;
    logic [2:0] buffer_dport;
    logic [FW-1:0] out_flit;
    logic cr_dut;

    int vectors = 0;
    int errors = 0;

    logic [FW-1:0] q[$];
    bit act = 0;
    logic [2:0] dp = 3'd0;
    bit m_drop = 0;
    bit m_credit = 0;
    bit e_ready, e_req, e_ovalid;
    logic [FW-1:0] e_flit;

    input_port_buffer #(.FLIT_W(FW), .DEPTH(D), .COORD_W(2), .X_ADDR(1), .Y_ADDR(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_ready     (in_ready),
        .buffer_req   (buffer_req),
        .buffer_dport (buffer_dport),
        .buffer_grant (buffer_grant),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .drop_pulse   (drop_pulse)
`ifdef INPUT_BUFFER_CREDIT_EN
        ,
        .credit_out   (cr_dut)
`endif
    );
`ifndef INPUT_BUFFER_CREDIT_EN
    assign cr_dut = m_credit;
`endif

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
        return {t, 26'($urandom), 2'(x), 2'(y)};
    endfunction

    // Router sits at (1,1): X first, then Y.
    function automatic logic [2:0] xy(input logic [FW-1:0] f);
        int x, y;
        x = int'(f[3:2]);
        y = int'(f[1:0]);
        if (x > 1) return 3'd3;
        if (x < 1) return 3'd1;
        if (y > 1) return 3'd4;
        if (y < 1) return 3'd2;
        return 3'd0;
    endfunction

    function automatic bit opens(input logic [FW-1:0] f);
        return f[FW-1:FW-2] == T_HEAD || f[FW-1:FW-2] == T_SINGLE;
    endfunction

    task automatic model_reset();
        q.delete();
        act = 0;
        dp = 3'd0;
        m_drop = 0;
        m_credit = 0;
    endtask

    task automatic drive(input stim_t s);
        in_valid = s.v;
        in_flit = s.f;
        buffer_grant = s.g;
        e_ready = q.size() < D;
        e_req = act && q.size() != 0;
        e_ovalid = e_req && s.g;
        e_flit = q.size() != 0 ? q[0] : 'x;
        @(negedge clk);
    endtask

    task automatic tick();
        bit dropnow, push;
        dropnow = !act && q.size() != 0 && !opens(q[0]);
        push = in_valid && e_ready;
        m_drop = dropnow;
        m_credit = e_ovalid || dropnow;
        if (!act && q.size() != 0 && opens(q[0])) begin
            act = 1;
            dp = xy(q[0]);
        end else if (e_ovalid && q[0][FW-1]) begin
            act = 0;
        end
        if (e_ovalid || dropnow) void'(q.pop_front());
        if (push) q.push_back(in_flit);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset: rdy/req/ov/drop/dport/cr got %b want 10000000",
                     {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut});
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        stim_t s[$];
        int req_cyc = -1;
        int ov_cnt = 0;
        s.push_back('{1, mk(T_SINGLE, 3, 1), 1});
        repeat (5) s.push_back('{0, '0, 1});
        foreach (s[i]) begin
            drive(s[i]);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL single ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            if (e_ovalid) begin
                vectors++;
                if (out_flit !== e_flit) begin
                    errors++;
                    $display("FAIL single flit: got %h want %h", out_flit, e_flit);
                end
            end
            if (buffer_req && req_cyc < 0) req_cyc = i;
            ov_cnt += int'(out_valid);
            tick();
        end
        vectors++;
        if (req_cyc != 2 || ov_cnt != 1) begin
            errors++;
            $display("FAIL single timing: req at %0d ov %0d want 2 and 1", req_cyc, ov_cnt);
        end
    endtask

    task automatic test_packet();
        stim_t s[$];
        logic [FW-1:0] sent[$];
        logic [FW-1:0] seen[$];
        sent = '{mk(T_HEAD, 1, 0), mk(T_BODY, 2, 2), mk(T_BODY, 3, 3), mk(T_TAIL, 0, 0)};
        foreach (sent[i]) s.push_back('{1, sent[i], 1});
        repeat (6) s.push_back('{0, '0, 1});
        foreach (s[i]) begin
            drive(s[i]);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL packet ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            if (out_valid) begin
                seen.push_back(out_flit);
                vectors++;
                if (buffer_dport !== 3'd2) begin
                    errors++;
                    $display("FAIL packet dport: got %0d want 2", buffer_dport);
                end
            end
            tick();
        end
        vectors++;
        if (seen != sent) begin
            errors++;
            $display("FAIL packet order: got %0d flits want 4 in order", seen.size());
        end
    endtask

    task automatic test_full();
        stim_t s[$];
        for (int i = 0; i < 5; i++) s.push_back('{1, mk(i == 0 ? T_HEAD : T_BODY, 0, 1), 0});
        s.push_back('{0, '0, 1});
        s.push_back('{1, mk(T_TAIL, 0, 0), 0});
        repeat (8) s.push_back('{0, '0, 1});
        foreach (s[i]) begin
            drive(s[i]);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL full ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            if (e_ovalid) begin
                vectors++;
                if (out_flit !== e_flit) begin
                    errors++;
                    $display("FAIL full flit: got %h want %h", out_flit, e_flit);
                end
            end
            if (i == 4 || i == 6) begin
                vectors++;
                if (in_ready !== (i == 6)) begin
                    errors++;
                    $display("FAIL full ready cyc %0d: got %b want %b", i, in_ready, i == 6);
                end
            end
            tick();
        end
    endtask

    task automatic test_drop();
        stim_t s[$];
        int drops = 0;
        s.push_back('{1, mk(T_BODY, 3, 3), 1});
        s.push_back('{0, '0, 1});
        s.push_back('{1, mk(T_TAIL, 0, 0), 0});
        repeat (4) s.push_back('{0, '0, 0});
        foreach (s[i]) begin
            drive(s[i]);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL drop ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            drops += int'(drop_pulse);
            tick();
        end
        vectors++;
        if (drops != 2) begin
            errors++;
            $display("FAIL drop count: got %0d want 2", drops);
        end
    endtask

    task automatic test_starve();
        stim_t s[$];
        int req_rise = 0;
        bit prev = 0;
        s.push_back('{1, mk(T_HEAD, 1, 1), 1});
        repeat (3) s.push_back('{0, '0, 1});
        s.push_back('{1, mk(T_TAIL, 2, 0), 1});
        repeat (4) s.push_back('{0, '0, 1});
        foreach (s[i]) begin
            drive(s[i]);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL starve ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            if (buffer_req) begin
                vectors++;
                if (buffer_dport !== 3'd0) begin
                    errors++;
                    $display("FAIL starve dport: got %0d want 0", buffer_dport);
                end
            end
            req_rise += int'(buffer_req && !prev);
            prev = buffer_req;
            tick();
        end
        vectors++;
        if (req_rise != 2) begin
            errors++;
            $display("FAIL starve req rises: got %0d want 2", req_rise);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        s.push_back('{1, mk(T_HEAD, 2, 2), 0});
        s.push_back('{1, mk(T_BODY, 1, 1), 0});
        s.push_back('{1, mk(T_BODY, 1, 1), 0});
        foreach (s[i]) begin
            drive(s[i]);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({buffer_req, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL async reset: req/ready got %b want 01", {buffer_req, in_ready});
        end
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s.delete();
        s.push_back('{1, mk(T_HEAD, 0, 1), 1});
        s.push_back('{1, mk(T_TAIL, 0, 1), 1});
        repeat (5) s.push_back('{0, '0, 1});
        foreach (s[i]) begin
            drive(s[i]);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL post-reset ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            if (buffer_req) begin
                vectors++;
                if (buffer_dport !== 3'd1) begin
                    errors++;
                    $display("FAIL post-reset dport: got %0d want 1", buffer_dport);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        stim_t s;
        logic [1:0] t;
        for (int i = 0; i < 400; i++) begin
            t = 2'($urandom_range(0, 3));
            s = '{$urandom_range(0, 9) < 6, mk(t, $urandom_range(0, 3), $urandom_range(0, 3)), $urandom_range(0, 9) < 7};
            drive(s);
            vectors++;
            if ({in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut} !== {e_ready, e_req, e_ovalid, m_drop, dp, m_credit}) begin
                errors++;
                $display("FAIL random ctl cyc %0d: got %b want %b", i,
                         {in_ready, buffer_req, out_valid, drop_pulse, buffer_dport, cr_dut}, {e_ready, e_req, e_ovalid, m_drop, dp, m_credit});
            end
            if (e_ovalid) begin
                vectors++;
                if (out_flit !== e_flit) begin
                    errors++;
                    $display("FAIL random flit cyc %0d: got %h want %h", i, out_flit, e_flit);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_full();
        test_drop();
        test_starve();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
